// File: rtl/key_event_module.sv
// Multi-key push-button front end: 2-FF synchroniser, tick-sampled debounce and
// per-key press / release / long-press / auto-repeat event generation.
module key_event_module #(
  parameter int KEY_NUM          = 4,
  parameter int ACTIVE_LOW       = 1,
  parameter int SAMPLE_CYCLES    = 100000,
  parameter int DEBOUNCE_SAMPLES = 10,
  parameter int LONG_SAMPLES     = 500,
  parameter int REPEAT_SAMPLES   = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  localparam int TW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int HW = (LONG_SAMPLES > 0) ? $clog2(LONG_SAMPLES + 1) : 1;
  localparam int RW = (REPEAT_SAMPLES > 0) ? $clog2(REPEAT_SAMPLES + 1) : 1;

  localparam bit LONG_EN   = (LONG_SAMPLES > 0);
  localparam bit REPEAT_EN = (REPEAT_SAMPLES > 0);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LIMIT  = DW'(DEBOUNCE_SAMPLES);
  localparam logic [HW-1:0] LONG_LIM  = HW'(LONG_SAMPLES);
  localparam logic [RW-1:0] REP_LIM   = RW'(REPEAT_SAMPLES);

  localparam logic [KEY_NUM-1:0] RELEASED_PIN =
    (ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  logic [KEY_NUM-1:0] sync_p0;
  logic [KEY_NUM-1:0] sync_p1;
  logic [KEY_NUM-1:0] act;
  logic [TW-1:0]      tick_cnt;
  logic               tick;

  logic [KEY_NUM-1:0] level_nx_v;
  logic [KEY_NUM-1:0] press_nx_v;
  logic [KEY_NUM-1:0] release_nx_v;
  logic [KEY_NUM-1:0] long_nx_v;
  logic [KEY_NUM-1:0] repeat_nx_v;

  // Stage p0/p1: synchroniser, reset to the released pin level so no phantom press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RELEASED_PIN;
      sync_p1 <= RELEASED_PIN;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  assign act = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nx;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nx;
    logic          level_nx;
    logic          press_nx;
    logic          release_nx;
    logic          long_nx;
    logic          repeat_nx;

    always_comb begin
      state_nx   = state;
      dcnt_nx    = dcnt;
      hcnt_nx    = hcnt;
      rcnt_nx    = rcnt;
      level_nx   = key_level[k];
      press_nx   = 1'b0;
      release_nx = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;

      if (tick) begin
        if (act[k] == key_level[k]) begin
          dcnt_nx = '0;
        end else if ((dcnt + DW'(1)) == DB_LIMIT) begin
          dcnt_nx  = '0;
          level_nx = ~key_level[k];
        end else begin
          dcnt_nx = dcnt + DW'(1);
        end

        // A debounced fall always takes priority over a long/repeat on the same tick
        case (state)
          S_IDLE: begin
            if (level_nx && !key_level[k]) begin
              state_nx = S_HELD;
              press_nx = 1'b1;
              hcnt_nx  = '0;
            end
          end
          S_HELD: begin
            if (!level_nx) begin
              state_nx   = S_IDLE;
              release_nx = 1'b1;
            end else if (LONG_EN) begin
              hcnt_nx = hcnt + HW'(1);
              if ((hcnt + HW'(1)) == LONG_LIM) begin
                state_nx = S_LONG;
                long_nx  = 1'b1;
                rcnt_nx  = '0;
              end
            end
          end
          S_LONG: begin
            if (!level_nx) begin
              state_nx   = S_IDLE;
              release_nx = 1'b1;
            end else if (REPEAT_EN) begin
              if ((rcnt + RW'(1)) == REP_LIM) begin
                repeat_nx = 1'b1;
                rcnt_nx   = '0;
              end else begin
                rcnt_nx = rcnt + RW'(1);
              end
            end
          end
          default: begin
            state_nx = S_IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_IDLE;
        dcnt  <= '0;
        hcnt  <= '0;
        rcnt  <= '0;
      end else begin
        state <= state_nx;
        dcnt  <= dcnt_nx;
        hcnt  <= hcnt_nx;
        rcnt  <= rcnt_nx;
      end
    end

    assign level_nx_v[k]   = level_nx;
    assign press_nx_v[k]   = press_nx;
    assign release_nx_v[k] = release_nx;
    assign long_nx_v[k]    = long_nx;
    assign repeat_nx_v[k]  = repeat_nx;
  end

  // Stage p2: registered outputs, events last exactly one clk after the tick edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      key_repeat  <= '0;
    end else begin
      key_level   <= level_nx_v;
      key_press   <= press_nx_v;
      key_release <= release_nx_v;
      key_long    <= long_nx_v;
      key_repeat  <= repeat_nx_v;
    end
  end

endmodule

// File: tb/tb_key_event_module.sv
// Scoreboard bench for key_event_module: directed key stimulus aligned to sample ticks,
// expected events queued with their cycle, monitors pop on every DUT event.
module tb_key_event_module;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
    logic [2:0] rep;
    logic [2:0] lvl;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] key_in_a;
  logic [2:0] lvl_a, press_a, rel_a, long_a, rep_a;
  logic [2:0] key_in_b;
  logic [2:0] lvl_b, press_b, rel_b, long_b, rep_b;

  int  cyc;
  int  checks;
  int  errors;
  ev_t qa[$];
  ev_t qb[$];
  ev_t ea;
  ev_t eb;

  key_event_module #(
    .KEY_NUM(3), .ACTIVE_LOW(1), .SAMPLE_CYCLES(4), .DEBOUNCE_SAMPLES(3),
    .LONG_SAMPLES(8), .REPEAT_SAMPLES(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_a), .key_level(lvl_a),
    .key_press(press_a), .key_release(rel_a), .key_long(long_a), .key_repeat(rep_a)
  );

  key_event_module #(
    .KEY_NUM(3), .ACTIVE_LOW(0), .SAMPLE_CYCLES(4), .DEBOUNCE_SAMPLES(3),
    .LONG_SAMPLES(0), .REPEAT_SAMPLES(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_b), .key_level(lvl_b),
    .key_press(press_b), .key_release(rel_b), .key_long(long_b), .key_repeat(rep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; sample-tick edges land on multiples of 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && ((press_a | rel_a | long_a | rep_a) != 3'b000)) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL dutA_unexpected cyc=%0d press=%b rel=%b long=%b rep=%b lvl=%b, required no event",
                 cyc, press_a, rel_a, long_a, rep_a, lvl_a);
      end else begin
        ea = qa.pop_front();
        if (ea.cyc != cyc || ea.press != press_a || ea.rel != rel_a || ea.lng != long_a ||
            ea.rep != rep_a || ea.lvl != lvl_a) begin
          errors++;
          $display("FAIL dutA_event got cyc=%0d p=%b r=%b l=%b rp=%b lv=%b required cyc=%0d p=%b r=%b l=%b rp=%b lv=%b",
                   cyc, press_a, rel_a, long_a, rep_a, lvl_a,
                   ea.cyc, ea.press, ea.rel, ea.lng, ea.rep, ea.lvl);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ((press_b | rel_b | long_b | rep_b) != 3'b000)) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL dutB_unexpected cyc=%0d press=%b rel=%b long=%b rep=%b lvl=%b, required no event",
                 cyc, press_b, rel_b, long_b, rep_b, lvl_b);
      end else begin
        eb = qb.pop_front();
        if (eb.cyc != cyc || eb.press != press_b || eb.rel != rel_b || eb.lng != long_b ||
            eb.rep != rep_b || eb.lvl != lvl_b) begin
          errors++;
          $display("FAIL dutB_event got cyc=%0d p=%b r=%b l=%b rp=%b lv=%b required cyc=%0d p=%b r=%b l=%b rp=%b lv=%b",
                   cyc, press_b, rel_b, long_b, rep_b, lvl_b,
                   eb.cyc, eb.press, eb.rel, eb.lng, eb.rep, eb.lvl);
        end
      end
    end
  end

  task automatic push_a(input int c, input logic [2:0] p, input logic [2:0] r,
                        input logic [2:0] l, input logic [2:0] rp, input logic [2:0] lv);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.rep = rp; e.lvl = lv;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [2:0] p, input logic [2:0] r,
                        input logic [2:0] lv);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = 3'b000; e.rep = 3'b000; e.lvl = lv;
    qb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Returns #1 after the next clk edge on which the DUT sampled a tick
  task automatic wait_tick();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 4 != 0);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   lvl_a,   3'b000);
    chk({tag, "_press"},   press_a, 3'b000);
    chk({tag, "_release"}, rel_a,   3'b000);
    chk({tag, "_long"},    long_a,  3'b000);
    chk({tag, "_repeat"},  rep_a,   3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tp;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    key_in_a = 3'b111;
    key_in_b = 3'b000;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press of key 0: held 6 ticks, no long press
    wait_tick();
    t0 = cyc;
    key_in_a[0] = 1'b0;
    push_a(t0 + 12, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001);
    wait_ticks(6);
    key_in_a[0] = 1'b1;
    push_a(t0 + 36, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000);
    wait_ticks(6);

    // Bounce on key 1: alternate samples never reach 3 in a row
    wait_tick();
    for (int i = 0; i < 10; i++) begin
      key_in_a[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end
    key_in_a[1] = 1'b1;
    wait_ticks(6);

    // Long and repeat on key 2; the fall lands on the +26 repeat tick and must win
    wait_tick();
    t0 = cyc;
    key_in_a[2] = 1'b0;
    tp = t0 + 12;
    push_a(tp, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
    push_a(tp + 32, 3'b000, 3'b000, 3'b100, 3'b000, 3'b100);
    for (int r = 11; r <= 23; r += 3)
      push_a(tp + 4 * r, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100);
    push_a(tp + 104, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    wait_ticks(3 + 23);
    key_in_a[2] = 1'b1;
    wait_ticks(8);

    // Simultaneous press and release of keys 0 and 2
    wait_tick();
    t0 = cyc;
    key_in_a = 3'b010;
    push_a(t0 + 12, 3'b101, 3'b000, 3'b000, 3'b000, 3'b101);
    wait_ticks(4);
    key_in_a = 3'b111;
    push_a(t0 + 28, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000);
    wait_ticks(6);

    // Reset while key 2 is in the repeat phase
    wait_tick();
    t0 = cyc;
    key_in_a[2] = 1'b0;
    push_a(t0 + 12, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
    push_a(t0 + 44, 3'b000, 3'b000, 3'b100, 3'b000, 3'b100);
    push_a(t0 + 56, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100);
    wait_ticks(14);
    @(posedge clk);
    #1;
    chk("pre_reset_level", lvl_a, 3'b100);
    chk_int("pre_reset_queue_empty", qa.size(), 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    push_a(12, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
    rst_n = 1'b1;
    wait_ticks(4);
    key_in_a[2] = 1'b1;
    push_a(28, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000);
    wait_ticks(6);

    // Active-high pins with long press disabled
    wait_tick();
    t0 = cyc;
    key_in_b[1] = 1'b1;
    push_b(t0 + 12, 3'b010, 3'b000, 3'b010);
    wait_ticks(20);
    key_in_b[1] = 1'b0;
    push_b(t0 + 92, 3'b000, 3'b010, 3'b000);
    wait_ticks(6);

    chk_int("dutA_pending_events", qa.size(), 0);
    chk_int("dutB_pending_events", qb.size(), 0);
    chk("final_level_a", lvl_a, 3'b000);
    chk("final_level_b", lvl_b, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_module.md
Name: key_event_module

Overview:
- Parametrised multi-key front end for board push-buttons.
- Synchronises each raw key input, then debounces each key independently by periodic sampling.
- Produces per-key events: debounced level, press pulse, release pulse, long-press pulse and auto-repeat pulses.
- Sits between board key pins and UI/control logic; every output is active-high whatever the pin polarity.

Parameters:
- KEY_NUM, 4, number of independent keys (1..32).
- ACTIVE_LOW, 1, 1 = pin low means pressed; 0 = pin high means pressed.
- SAMPLE_CYCLES, 100000, clk cycles per sample tick (2 ms at 50 MHz); minimum 2.
- DEBOUNCE_SAMPLES, 10, consecutive agreeing samples needed to change the debounced level (1..255).
- LONG_SAMPLES, 500, ticks of continuous hold after the press event before key_long fires; 0 disables long and repeat.
- REPEAT_SAMPLES, 100, tick period of key_repeat after key_long; 0 disables repeat.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  KEY_NUM  raw asynchronous key pins
- key_level  out  KEY_NUM  debounced pressed state, 1 = pressed
- key_press  out  KEY_NUM  1-clk pulse when key_level rises
- key_release  out  KEY_NUM  1-clk pulse when key_level falls
- key_long  out  KEY_NUM  1-clk pulse when hold reaches LONG_SAMPLES
- key_repeat  out  KEY_NUM  1-clk pulse every REPEAT_SAMPLES ticks after key_long while held

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs, the tick counter, and all per-key counters and states clear to 0.
  - Synchroniser flops clear to the released pin level (all 1 if ACTIVE_LOW, else all 0).
- Input path:
  - 2-FF synchroniser per bit.
  - Then normalisation act = ACTIVE_LOW ? ~sync : sync.
- Tick: a shared counter runs 0..SAMPLE_CYCLES-1 and wraps. tick is high for one clk when the counter equals SAMPLE_CYCLES-1. All per-key state updates only on clk edges where tick=1.
- Per-key debounce counter dcnt:
  - On tick, if act == key_level, dcnt clears to 0.
  - Otherwise dcnt increments.
  - When the incremented value equals DEBOUNCE_SAMPLES, key_level toggles and dcnt clears.
  - A single disagreeing sample therefore restarts the count.
- Per-key state machine, evaluated on tick:
  - IDLE -> HELD on debounced rise; pulse key_press; clear hcnt.
  - HELD: hcnt increments, saturating at LONG_SAMPLES. When hcnt reaches LONG_SAMPLES (LONG_SAMPLES ticks after the press tick), pulse key_long, go to LONG, clear rcnt.
  - LONG: rcnt increments; when it reaches REPEAT_SAMPLES, pulse key_repeat and clear rcnt. If REPEAT_SAMPLES=0, stay in LONG with no pulses.
  - HELD/LONG -> IDLE on debounced fall; pulse key_release. No long or repeat on that tick; a fall wins over a simultaneous long or repeat.
- Outputs are registered. Each event bit is high for exactly one clk, the cycle after the tick edge that caused it. key_level changes in that same cycle.
- Latency: a clean pin edge is reflected in key_level between 2+(DEBOUNCE_SAMPLES-1)*SAMPLE_CYCLES+1 and 2+DEBOUNCE_SAMPLES*SAMPLE_CYCLES+1 clks.
- Keys are fully independent. Any number of keys may raise events in the same cycle.
- Counter widths are sized with $clog2 from the parameters. hcnt and rcnt never wrap.
- Reset mid-hold: after release of reset, a still-held key is re-debounced from released and produces a fresh key_press. No key_release is emitted for the interrupted hold.

Test Plan:
- Common parameters for all scenarios: KEY_NUM=3, ACTIVE_LOW=1, SAMPLE_CYCLES=4, DEBOUNCE_SAMPLES=3, LONG_SAMPLES=8, REPEAT_SAMPLES=3.
- Clean press: drive key_in[0]=0 for 6 ticks, then release.
  - key_press=3'b001 for 1 clk after the 3rd low sample; key_level[0]=1.
  - key_release=3'b001 after the 3rd high sample.
  - key_long is never asserted.
- Bounce: toggle key_in[1] every 4 clks for 40 clks, then hold it high. All outputs stay 0 throughout.
- Long and repeat: hold key_in[2] low for 25 ticks after key_press.
  - key_long[2] fires 8 ticks after the press tick.
  - key_repeat[2] fires at +11, +14, +17, +20 and +23 ticks.
  - Release then gives one key_release[2] pulse and no further repeats.
- Simultaneous: press key_in[0] and key_in[2] on the same clk. key_press=3'b101 in a single cycle; later, simultaneous releases give key_release=3'b101.
- Reset mid-hold: assert rst_n=0 while key 2 is in the repeat phase.
  - All outputs read 0 asynchronously.
  - After rst_n=1 with the key still held, key_press[2] fires after 3 ticks (plus sync latency).
  - No key_release[2] pulse is emitted.
- Polarity and disable: set ACTIVE_LOW=0, LONG_SAMPLES=0 and hold key_in[1]=1 for 20 ticks. key_press[1] fires once; key_long and key_repeat stay 0.
